// File: rtl/mul_share_pkg.sv
// Shared constants, state encoding and carry-save helper for the shared multiplier block.
package mul_share_pkg;

    localparam int NREQ_DEF = 4;
    localparam int IDW_DEF  = 2;
    localparam int OPW      = 8;
    localparam int PW       = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        HOLD = 2'd2
    } state_t;

    // Carry output of a 3:2 compressor row, already aligned to the next weight.
    function automatic logic [PW-1:0] csa_carry(input logic [PW-1:0] x, input logic [PW-1:0] y,
                                                input logic [PW-1:0] z);
        return ((x & y) | (x & z) | (y & z)) << 1;
    endfunction

endpackage

// File: rtl/rr_arb_nreq.sv
// Combinational round-robin picker: first set request scanning from ptr upward, modulo NREQ.
module rr_arb_nreq #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  idx,
    output logic            any
);

    logic [IDW:0] pos;

    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        pos   = '0;
        for (int k = 0; k < NREQ; k++) begin
            pos = {1'b0, ptr} + (IDW+1)'(k);
            if (pos >= (IDW+1)'(NREQ)) pos = pos - (IDW+1)'(NREQ);
            if (!any && req[pos[IDW-1:0]]) begin
                any                 = 1'b1;
                grant[pos[IDW-1:0]] = 1'b1;
                idx                 = pos[IDW-1:0];
            end
        end
    end

endmodule

// File: rtl/wallace_8bit.sv
// Combinational 8x8 unsigned multiplier: partial products reduced by a 3:2 carry-save tree.
module wallace_8bit
    import mul_share_pkg::*;
(
    input  logic [OPW-1:0] a,
    input  logic [OPW-1:0] b,
    output logic [PW-1:0]  p
);

    logic [PW-1:0] pp [OPW];
    logic [PW-1:0] s0, c0, s1, c1, s2, c2, s3, c3, s4, c4, s5, c5;

    always_comb begin
        for (int i = 0; i < OPW; i++) begin
            pp[i] = b[i] ? (PW'(a) << i) : '0;
        end
    end

    // Reduction 8 -> 6 -> 4 -> 3 -> 2 rows; the product fits in 16 bits so bits shifted past the MSB are zero.
    assign s0 = pp[0] ^ pp[1] ^ pp[2];
    assign c0 = csa_carry(pp[0], pp[1], pp[2]);
    assign s1 = pp[3] ^ pp[4] ^ pp[5];
    assign c1 = csa_carry(pp[3], pp[4], pp[5]);
    assign s2 = s0 ^ c0 ^ s1;
    assign c2 = csa_carry(s0, c0, s1);
    assign s3 = c1 ^ pp[6] ^ pp[7];
    assign c3 = csa_carry(c1, pp[6], pp[7]);
    assign s4 = s2 ^ c2 ^ s3;
    assign c4 = csa_carry(s2, c2, s3);
    assign s5 = s4 ^ c4 ^ c3;
    assign c5 = csa_carry(s4, c4, c3);
    assign p  = s5 + c5;

endmodule

// File: rtl/mul_share_arb.sv
// One 8x8 multiplier shared by NREQ requesters: round-robin accept, one op in flight, held result.
// Optional MUL_SHARE_SIGNED_EN adds per-request two's-complement operands via req_signed.
module mul_share_arb
    import mul_share_pkg::*;
#(
    parameter int NREQ = NREQ_DEF,
    parameter int IDW  = IDW_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [8*NREQ-1:0] req_a,
    input  logic [8*NREQ-1:0] req_b,
`ifdef MUL_SHARE_SIGNED_EN
    input  logic [NREQ-1:0]   req_signed,
`endif
    output logic [NREQ-1:0]   req_ready,
    output logic [NREQ-1:0]   resp_valid,
    output logic [PW-1:0]     resp_p,
    input  logic [NREQ-1:0]   resp_ready,
    output logic              busy,
    output logic [IDW-1:0]    grant_id
);

    // Handshakes: a request transfers when req_valid[i] && req_ready[i]; a result transfers
    // when resp_valid[id_q] && resp_ready[id_q]. resp_p is stable for as long as resp_valid is high.
    state_t          state;
    logic [IDW-1:0]  rr_ptr, id_q, win_idx;
    logic [OPW-1:0]  op_a, op_b, sel_a, sel_b, mul_a, mul_b;
    logic [PW-1:0]   p_q, mul_p, prod_fin;
    logic [NREQ-1:0] arb_req, win_oh;
    logic            win_any, hs;

    assign hs      = (state == HOLD) && resp_ready[id_q];
    assign arb_req = ((state == IDLE) || hs) ? req_valid : '0;

    rr_arb_nreq #(.NREQ(NREQ), .IDW(IDW)) u_arb (
        .req   (arb_req),
        .ptr   (rr_ptr),
        .grant (win_oh),
        .idx   (win_idx),
        .any   (win_any)
    );

    assign sel_a = req_a[win_idx*OPW +: OPW];
    assign sel_b = req_b[win_idx*OPW +: OPW];

`ifdef MUL_SHARE_SIGNED_EN
    logic sgn_q;
    // Multiply magnitudes, then restore the sign; -128 maps to magnitude 8'h80 = 128.
    assign mul_a    = (sgn_q && op_a[OPW-1]) ? -op_a : op_a;
    assign mul_b    = (sgn_q && op_b[OPW-1]) ? -op_b : op_b;
    assign prod_fin = (sgn_q && (op_a[OPW-1] ^ op_b[OPW-1])) ? -mul_p : mul_p;
`else
    assign mul_a    = op_a;
    assign mul_b    = op_b;
    assign prod_fin = mul_p;
`endif

    wallace_8bit u_mul (
        .a (mul_a),
        .b (mul_b),
        .p (mul_p)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            rr_ptr <= '0;
            op_a   <= '0;
            op_b   <= '0;
            p_q    <= '0;
            id_q   <= '0;
`ifdef MUL_SHARE_SIGNED_EN
            sgn_q  <= 1'b0;
`endif
        end else begin
            if (win_any) begin
                op_a   <= sel_a;
                op_b   <= sel_b;
                id_q   <= win_idx;
                rr_ptr <= (win_idx == IDW'(NREQ-1)) ? '0 : win_idx + IDW'(1);
`ifdef MUL_SHARE_SIGNED_EN
                sgn_q  <= req_signed[win_idx];
`endif
            end
            case (state)
                IDLE: if (win_any) state <= CALC;
                CALC: begin
                    p_q   <= prod_fin;
                    state <= HOLD;
                end
                HOLD: begin
                    if (win_any) state <= CALC;
                    else if (hs) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign req_ready = rst_n ? win_oh : '0;
    assign resp_p    = p_q;
    assign busy      = (state != IDLE);
    assign grant_id  = (state == IDLE) ? '0 : id_q;

    always_comb begin
        resp_valid = '0;
        if (state == HOLD) resp_valid[id_q] = 1'b1;
    end

endmodule
